// File: rtl/oc_q3_q4.sv
// Registered 3-input ones counter: a NAND-only (Q3) and a NOR-only (Q4) gate network, plus a registered LSB cross-check.
// Latency 1 cycle from a/b/c to every output; there is no flow control and no backpressure.
module oc_q3_q4 (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic q3_y0,
   output logic q3_y1,
   output logic q4_y0,
   output logic mismatch
);

   // Q3 parity: XOR(a,b) from four NANDs, then the same cell structure with c.
   logic n_ab, n_a, n_b, x_ab;
   logic n_xc, n_x, n_c, q3_par;

   nand g_p0 (n_ab, a, b);
   nand g_p1 (n_a, a, n_ab);
   nand g_p2 (n_b, b, n_ab);
   nand g_p3 (x_ab, n_a, n_b);
   nand g_p4 (n_xc, x_ab, c);
   nand g_p5 (n_x, x_ab, n_xc);
   nand g_p6 (n_c, c, n_xc);
   nand g_p7 (q3_par, n_x, n_c);

   // Q3 majority: NAND-NAND sum of products; the 3-input OR is folded into 2-input NANDs.
   logic p_ab, p_bc, p_ac, t_ab_bc, u_ab_bc, q3_maj;

   nand g_m0 (p_ab, a, b);
   nand g_m1 (p_bc, b, c);
   nand g_m2 (p_ac, a, c);
   nand g_m3 (t_ab_bc, p_ab, p_bc);
   nand g_m4 (u_ab_bc, t_ab_bc, t_ab_bc);
   nand g_m5 (q3_maj, u_ab_bc, p_ac);

   // Q4 parity: two NOR-built XNOR stages; XNOR(XNOR(a,b),c) equals a^b^c.
   logic m_ab, m_a, m_b, xn_ab;
   logic m_xc, m_x, m_c, q4_par;

   nor g_n0 (m_ab, a, b);
   nor g_n1 (m_a, a, m_ab);
   nor g_n2 (m_b, b, m_ab);
   nor g_n3 (xn_ab, m_a, m_b);
   nor g_n4 (m_xc, xn_ab, c);
   nor g_n5 (m_x, xn_ab, m_xc);
   nor g_n6 (m_c, c, m_xc);
   nor g_n7 (q4_par, m_x, m_c);

   logic lsb_diff;
   assign lsb_diff = q3_par ^ q4_par;

   always_ff @(posedge clk) begin
      if (rst) begin
         q3_y0    <= 1'b0;
         q3_y1    <= 1'b0;
         q4_y0    <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         q3_y0    <= q3_par;
         q3_y1    <= q3_maj;
         q4_y0    <= q4_par;
         mismatch <= lsb_diff;
      end
   end

endmodule

// File: tb/tb_oc_q3_q4.sv
// Scoreboard bench for oc_q3_q4: the driver queues the expected count per edge, the monitor pops and compares.
module tb_oc_q3_q4;

   logic clk = 1'b0;
   logic rst, a, b, c;
   logic q3_y0, q3_y1, q4_y0, mismatch;

   always #5 clk = ~clk;

   oc_q3_q4 dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .c        (c),
      .q3_y0    (q3_y0),
      .q3_y1    (q3_y1),
      .q4_y0    (q4_y0),
      .mismatch (mismatch)
   );

   typedef struct {
      logic y1;
      logic y0;
      logic q4;
      logic mm;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   check_cnt = 0;

   task automatic chk(input string name, input logic act, input logic req);
      check_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
   endtask

   // Reference: the count is the integer sum of the three bits; reset forces zero.
   function automatic exp_t model(input logic r, input logic ia, input logic ib, input logic ic);
      int   cnt;
      exp_t e;
      cnt  = r ? 0 : (int'(ia) + int'(ib) + int'(ic));
      e.y1 = (cnt >= 2);
      e.y0 = (cnt % 2 == 1);
      e.q4 = (cnt % 2 == 1);
      e.mm = 1'b0;
      return e;
   endfunction

   // Drives one vector for the next rising edge, optionally pulsing a between edges.
   task automatic step(input logic r, input logic [2:0] abc, input bit glitch = 0);
      rst = r;
      {a, b, c} = abc;
      exp_q.push_back(model(r, abc[2], abc[1], abc[0]));
      if (glitch) begin
         #1 a = 1'b1;
         #1 a = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            check_cnt++;
            $display("FAIL scoreboard_empty: got no expected entry at t=%0t, expected one", $time);
         end else begin
            e = exp_q.pop_front();
            chk("q3_y1", q3_y1, e.y1);
            chk("q3_y0", q3_y0, e.y0);
            chk("q4_y0", q4_y0, e.q4);
            chk("mismatch", mismatch, e.mm);
         end
      end
   end

   initial begin : driver
      logic [2:0] v;
      // Reset held two edges with all inputs high, then release.
      step(1'b1, 3'b111);
      step(1'b1, 3'b111);
      step(1'b0, 3'b111);
      // Exhaustive sweep.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         step(1'b0, v);
      end
      // Incremental walk.
      step(1'b0, 3'b000);
      step(1'b0, 3'b100);
      step(1'b0, 3'b110);
      // Mid-stream reset.
      step(1'b0, 3'b011);
      step(1'b1, 3'b111);
      step(1'b0, 3'b111);
      // Glitch on a between edges with bc=01.
      step(1'b0, 3'b001);
      step(1'b0, 3'b001, 1'b1);
      step(1'b0, 3'b001, 1'b1);
      // Hold.
      for (int i = 0; i < 5; i++) step(1'b0, 3'b101);
      // Random traffic with occasional reset.
      for (int i = 0; i < 200; i++) begin
         v = 3'($urandom_range(0, 7));
         step(($urandom_range(0, 15) == 0), v);
      end
      check_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/oc_q3_q4.md
# oc_q3_q4

Registered three-input ones counter that reports how many of inputs `a`, `b`, `c` are high as a 2-bit value {y1, y0}. It holds two independently built gate networks for the same function: the Q3 network produces both bits and the Q4 network produces the LSB. A registered cross-check flag compares the two LSBs. The block is the synchronous wrapper around the OC_Q3_y0, OC_Q3_y1 and OC_Q4_y0 logic and feeds downstream logic that needs a clean, clock-aligned count.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `a`  input  1  data bit (MSB of stimulus ordering)
- `b`  input  1  data bit
- `c`  input  1  data bit (LSB of stimulus ordering)
- `q3_y0`  output  1  registered LSB of ones count, Q3 network (parity)
- `q3_y1`  output  1  registered MSB of ones count, Q3 network (majority)
- `q4_y0`  output  1  registered LSB of ones count, Q4 network (parity)
- `mismatch`  output  1  registered flag: Q3 and Q4 LSBs disagree

## Operation
- Ones count = a + b + c, range 0..3, encoded {y1, y0}.
- y0 = a ^ b ^ c (odd parity). y1 = a&b | b&c | a&c (majority).
- Truth table for abc → {y1, y0}:
  - 000 → 00, 001 → 01, 010 → 01, 011 → 10
  - 100 → 01, 101 → 10, 110 → 10, 111 → 11
- Q3 network: built structurally from 2-input NAND primitives only, with no behavioural operators. y0 is an XOR-of-XOR built from NAND cells. y1 is a NAND-NAND sum of products.
- Q4 network: built structurally from 2-input NOR primitives only. It produces y0 only.
- Both networks read the same live `a`, `b`, `c` inputs. They are combinational, with no internal state.
- `mismatch` = Q3 y0 XOR Q4 y0, computed combinationally from the network outputs and then registered.
  - With a correct implementation it is always 0.
  - It exists for fault injection and gate-level checks.
- No input registration. Inputs are sampled directly at the clock edge.

## Timing
- All outputs are registered on the rising edge of `clk`. Latency is 1 cycle from an input change to the output.
- `rst` is high at an edge → `q3_y0`, `q3_y1`, `q4_y0` and `mismatch` all become 0 at that edge. Reset takes priority over data.
- The first edge with `rst` low loads the count for the inputs present at that edge.
- Reset asserted mid-stream: outputs clear at the next edge regardless of the inputs. No stale value reappears after release; the output reflects only the inputs at the first post-reset edge.
- Inputs held constant → outputs stay constant. There is no toggling and no accumulation across cycles.
- Inputs changing between edges have no effect. Only values meeting setup at the edge matter.
- Several inputs changing in the same cycle → the output is the count of the new vector. There are no intermediate values, because the glitches of the combinational networks are masked by the register.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with abc=111 → all outputs 0. Release → after 1 edge, q3_y1=1, q3_y0=1, q4_y0=1, mismatch=0.
- Exhaustive sweep: apply abc = 000, 001, 010, 011, 100, 101, 110, 111, one per cycle. Expect {q3_y1, q3_y0} = 00, 01, 01, 10, 01, 10, 10, 11, one cycle later each. Require q4_y0 == q3_y0 and mismatch=0 throughout.
- Incremental walk: abc 000 → 100 → 110. Outputs go 00 → 01 → 10 with 1-cycle latency. q4_y0 follows 0, 1, 0.
- Mid-stream reset: apply abc=011 and then 111, and assert `rst` on the edge where 111 is applied → outputs 0 at that edge. The next edge with `rst`=0 and abc=111 → 11.
- Mid-cycle glitch: toggle `a` high and back low entirely between two edges with bc=01 → outputs stay {0,1}, mismatch=0.
- Hold: keep abc=101 for 5 cycles → q3_y1=1, q3_y0=0, q4_y0=0 on every cycle.
